// File: rtl/fft_input_loader.sv
// Collects 16 complex samples into a bit-reversed frame buffer for the butterfly loop.
// Handshakes the frame out with Start/Done and recycles the buffer afterwards.
module fft_input_loader #(
  parameter int N = 16,
  parameter int W = 64
) (
  input  logic         Clock,
  input  logic         Areset,
  input  logic         InValid,
  input  logic [W-1:0] InReal,
  input  logic [W-1:0] InImag,
  output logic         InReady,
  input  logic         Flush,
  input  logic         Done,
  output logic [W-1:0] KgrpsReal [0:N-1],
  output logic [W-1:0] KgrpsImag [0:N-1],
  output logic         Start,
  output logic [4:0]   Count,
  output logic         Overrun
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] buf_re [0:N-1];
  logic [W-1:0] buf_im [0:N-1];

  logic       accept;
  logic       last_sample;
  logic       clear;
  logic [3:0] wr_idx;

  assign accept      = InValid && InReady;
  assign last_sample = (Count == 5'd15);
  assign clear       = (state == RELEASE) && !Done;
  assign wr_idx      = {Count[0], Count[1], Count[2], Count[3]};

  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // A flush with nothing held and nothing arriving would hand out an empty frame.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (accept && last_sample) begin
          state_nxt = HOLD;
        end else if (Flush && (accept || Count != 5'd0)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (Done) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!Done) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    InReady = 1'b0;
    Start   = 1'b0;
    case (state)
      FILL:    InReady = 1'b1;
      HOLD:    Start   = 1'b1;
      RELEASE: begin
        InReady = 1'b0;
        Start   = 1'b0;
      end
      default: begin
        InReady = 1'b0;
        Start   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) begin
      Count <= '0;
    end else if (clear) begin
      Count <= '0;
    end else if (accept) begin
      Count <= Count + 5'd1;
    end
  end

  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) begin
      for (int unsigned i = 0; i < N; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else if (clear) begin
      for (int unsigned i = 0; i < N; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else if (accept) begin
      buf_re[wr_idx] <= InReal;
      buf_im[wr_idx] <= InImag;
    end
  end

  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) begin
      Overrun <= 1'b0;
    end else if (InValid && !InReady) begin
      Overrun <= 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      KgrpsReal[i] = buf_re[i];
      KgrpsImag[i] = buf_im[i];
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: full frame, partial flush, handshake,
// overrun, flush on the last sample and asynchronous reset.
module tb_fft_input_loader;

  logic        Clock;
  logic        Areset;
  logic        InValid;
  logic [63:0] InReal;
  logic [63:0] InImag;
  logic        InReady;
  logic        Flush;
  logic        Done;
  logic [63:0] KgrpsReal [0:15];
  logic [63:0] KgrpsImag [0:15];
  logic        Start;
  logic [4:0]  Count;
  logic        Overrun;

  int errors = 0;
  int checks = 0;

  // Hand-computed 4-bit reversal of 0..15.
  int rev [0:15] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_input_loader #(.N(16), .W(64)) dut (
    .Clock     (Clock),
    .Areset    (Areset),
    .InValid   (InValid),
    .InReal    (InReal),
    .InImag    (InImag),
    .InReady   (InReady),
    .Flush     (Flush),
    .Done      (Done),
    .KgrpsReal (KgrpsReal),
    .KgrpsImag (KgrpsImag),
    .Start     (Start),
    .Count     (Count),
    .Overrun   (Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [63:0] re, input logic [63:0] im, input logic fl);
    InValid = 1'b1;
    InReal  = re;
    InImag  = im;
    Flush   = fl;
    tick();
    InValid = 1'b0;
    Flush   = 1'b0;
  endtask

  initial begin
    Areset  = 1'b0;
    InValid = 1'b0;
    InReal  = '0;
    InImag  = '0;
    Flush   = 1'b0;
    Done    = 1'b0;
    #1;
    check("rst_start", Start, 0);
    check("rst_count", Count, 0);
    check("rst_overrun", Overrun, 0);
    check("rst_kr5", KgrpsReal[5], 0);
    #20;
    Areset = 1'b1;
    #1;

    // Full frame on consecutive cycles
    for (int k = 0; k < 16; k++) begin
      InValid = 1'b1;
      InReal  = 64'(k);
      InImag  = 64'(100 + k);
      tick();
      if (k == 14) begin
        check("full_start_early", Start, 0);
        check("full_ready_early", InReady, 1);
      end
    end
    InValid = 1'b0;
    check("full_start", Start, 1);
    check("full_ready", InReady, 0);
    check("full_count", Count, 16);
    check("full_kr8", KgrpsReal[8], 1);
    check("full_kr1", KgrpsReal[1], 8);
    check("full_kr15", KgrpsReal[15], 15);
    check("full_ki8", KgrpsImag[8], 101);
    for (int k = 0; k < 16; k++) begin
      check("full_kr", KgrpsReal[rev[k]], 64'(k));
      check("full_ki", KgrpsImag[rev[k]], 64'(100 + k));
    end

    // Hold with Done low; Flush must be ignored here
    for (int i = 0; i < 10; i++) begin
      Flush = (i == 3);
      tick();
      check("hold_start", Start, 1);
    end
    Flush = 1'b0;

    // Overrun in HOLD
    push(64'd999, 64'd999, 1'b0);
    check("ovr_flag", Overrun, 1);
    check("ovr_count", Count, 16);
    check("ovr_kr0", KgrpsReal[0], 0);
    check("ovr_kr8", KgrpsReal[8], 1);
    check("ovr_start", Start, 1);

    // Release handshake
    Done = 1'b1;
    tick();
    check("rel_start", Start, 0);
    check("rel_ready", InReady, 0);
    check("rel_count", Count, 16);
    Done = 1'b0;
    tick();
    check("fill_ready", InReady, 1);
    check("fill_count", Count, 0);
    check("fill_start", Start, 0);
    for (int k = 0; k < 16; k++) begin
      check("fill_kr_zero", KgrpsReal[k], 0);
      check("fill_ki_zero", KgrpsImag[k], 0);
    end
    check("ovr_sticky", Overrun, 1);

    // Flush with empty frame ignored; Done ignored in FILL
    Flush = 1'b1;
    Done  = 1'b1;
    tick();
    Flush = 1'b0;
    Done  = 1'b0;
    check("eflush_start", Start, 0);
    check("eflush_ready", InReady, 1);

    // Partial frame then Flush
    push(64'd5, 64'd50, 1'b0);
    push(64'd6, 64'd60, 1'b0);
    push(64'd7, 64'd70, 1'b0);
    check("part_start_pre", Start, 0);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("part_start", Start, 1);
    check("part_count", Count, 3);
    check("part_kr0", KgrpsReal[0], 5);
    check("part_kr8", KgrpsReal[8], 6);
    check("part_kr4", KgrpsReal[4], 7);
    check("part_ki4", KgrpsImag[4], 70);
    for (int k = 0; k < 16; k++) begin
      if (k != 0 && k != 8 && k != 4) check("part_kr_zero", KgrpsReal[k], 0);
    end
    Done = 1'b1;
    tick();
    Done = 1'b0;
    tick();
    check("part_back_fill", Count, 0);

    // 16th sample together with Flush
    for (int k = 0; k < 15; k++) push(64'(200 + k), 64'(300 + k), 1'b0);
    check("sim_start_pre", Start, 0);
    push(64'd215, 64'd315, 1'b1);
    check("sim_start", Start, 1);
    check("sim_count", Count, 16);
    for (int k = 0; k < 16; k++) check("sim_kr", KgrpsReal[rev[k]], 64'(200 + k));
    tick();
    check("sim_hold", Start, 1);
    check("sim_count_hold", Count, 16);

    // Asynchronous reset mid-cycle in HOLD
    #2;
    Areset = 1'b0;
    #1;
    check("arst_start", Start, 0);
    check("arst_count", Count, 0);
    check("arst_overrun", Overrun, 0);
    check("arst_kr15", KgrpsReal[15], 0);
    check("arst_ki0", KgrpsImag[0], 0);
    #3;
    Areset = 1'b1;
    push(64'd42, 64'd43, 1'b0);
    check("post_rst_count", Count, 1);
    check("post_rst_kr0", KgrpsReal[0], 42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 Parameter N, default 16, meaning points per frame; only 16 is supported.
REQ-002 Parameter W, default 64, meaning bits per real or imaginary word, treated as opaque data.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Areset  input  1  asynchronous active-low reset.
REQ-005 InValid  input  1  sample present on InReal/InImag.
REQ-006 InReal  input  64  real part of incoming sample.
REQ-007 InImag  input  64  imaginary part of incoming sample.
REQ-008 InReady  output  1  loader accepts a sample this cycle.
REQ-009 Flush  input  1  close the current partial frame early.
REQ-010 Done  input  1  downstream butterfly loop finished with the frame.
REQ-011 KgrpsReal  output  64 x 16  real parts of the frame, in bit-reversed order.
REQ-012 KgrpsImag  output  64 x 16  imaginary parts of the frame, in bit-reversed order.
REQ-013 Start  output  1  level, frame valid; drives the butterfly loop's In.
REQ-014 Count  output  5  samples accepted in the current frame, 0..16.
REQ-015 Overrun  output  1  sticky flag: sample offered while InReady=0.

Function
REQ-016 The FSM SHALL have states FILL, HOLD and RELEASE, held in registered state with a combinational next-state.
REQ-017 FILL SHALL drive InReady=1 and Start=0.
REQ-018 A sample SHALL be accepted on a rising edge with InValid=1 and InReady=1.
- It is written to buffer index bitrev4(Count[3:0]), i.e. {c0,c1,c2,c3}.
- Count increments by 1.
REQ-019 Accepting with Count=15 SHALL set Count=16 and enter HOLD on that edge.
REQ-020 Flush=1 in FILL with Count>0 SHALL enter HOLD on that edge.
- Entries not yet written keep value 0.
REQ-021 Flush=1 together with an accepted sample SHALL write the sample first, then enter HOLD.
REQ-022 Flush=1 in FILL with Count=0 and no accepted sample SHALL be ignored.
REQ-023 HOLD SHALL drive Start=1 and InReady=0.
- Kgrps outputs are held constant.
- HOLD exits to RELEASE on the first edge with Done=1.
REQ-024 RELEASE SHALL drive Start=0 and InReady=0.
- RELEASE waits for Done=0.
- On that edge it clears all 32 buffer words to 0, sets Count=0 and returns to FILL.
REQ-025 Done SHALL be ignored in FILL.
REQ-026 Flush SHALL be ignored in HOLD and RELEASE.
REQ-027 Overrun SHALL set on any edge with InValid=1 and InReady=0.
- It stays set until reset.
- The offered sample is discarded.
REQ-028 Kgrps outputs SHALL be driven directly from buffer registers.
- Start rises the cycle after the last write.
- Data is therefore stable when Start is first seen high.
REQ-029 Latency SHALL be one cycle: from the edge accepting the 16th sample (or the Flush edge) to Start=1.
REQ-030 Throughput SHALL be at most one sample per cycle, with no gap cycles inside FILL.

Reset
REQ-031 Areset=0 SHALL immediately force the following, independent of Clock:
- state FILL, Count=0, all buffer words 0;
- Start=0, Overrun=0, InReady=1 (InReady=0 while Areset=0 is also allowed).
REQ-032 Reset asserted mid-FILL or in HOLD SHALL discard the partial or held frame.
- Start falls asynchronously.
REQ-033 After Areset rises, the first rising edge SHALL be able to accept a sample.

Verification
REQ-034 Full frame: push samples with real=k, imag=100+k for k=0..15 on consecutive cycles.
- Required: Start=1 one cycle after the 16th accept.
- KgrpsReal[bitrev(k)]=k; e.g. index 8 = 1, index 1 = 8, index 15 = 15.
REQ-035 Flush partial: push 3 samples (real 5,6,7), then Flush.
- Required: HOLD with KgrpsReal[0]=5, [8]=6, [4]=7, all others 0, Count=3.
REQ-036 Handshake release:
- Hold Done=0 for 10 cycles in HOLD: Start stays 1.
- Raise Done for 1 cycle: Start=0 next cycle.
- Lower Done: FILL with Count=0 and all outputs 0.
REQ-037 Overrun: InValid=1 during HOLD.
- Required: Overrun=1, buffer unchanged, Count stays 16.
REQ-038 Simultaneous: 15 samples accepted, then the 16th accepted with Flush=1 on the same edge.
- Required: all 16 entries written, HOLD entered once, Count=16.
REQ-039 Async reset: assert Areset=0 mid-cycle in HOLD.
- Required: Start=0 and Count=0 before the next clock edge.
- All Kgrps=0.
